soc_run_monitor: RTL and testbench

Synthesizable run-control and pass/fail monitor for SoCTop bring-up on the Gowin FPGA and in simulation. It generalises the fixed bench reset-button sequence into a parametrised sequence generator driving the active-low reset button on `gpio_in[0]`. It samples the CPU write-back PC and exception number, and reports heartbeat, pass, timeout and stall through registered status outputs. It sits beside the CPU, either in the testbench or in the FPGA top, so on-board LEDs can show run state.

---
 rtl/soc_run_monitor.sv | 208 ++++++++++++++++++++
 tb/tb_soc_run_monitor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_run_monitor.sv
// Run-control and pass/fail monitor for SoCTop bring-up: generates the reset-button press
// sequence, then watches the write-back PC and exceptions for pass, timeout and stall.
module soc_run_monitor #(
  parameter int unsigned PC_WIDTH         = 32,
  parameter int unsigned EXCP_WIDTH       = 7,
  parameter int unsigned SUCCESS_BIT      = 6,
  parameter int unsigned NUM_RESETS       = 2,
  parameter int unsigned PRE_CYCLES       = 10000000,
  parameter int unsigned PULSE_CYCLES     = 100,
  parameter int unsigned HEARTBEAT_CYCLES = 10000,
  parameter logic [63:0] TIMEOUT_CYCLES   = 64'h0000_00FF_FFFF_FFFF,
  parameter int unsigned STALL_CYCLES     = 1000000,
  parameter bit          CONT_CHECK       = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   wb_pc,
  input  logic                  ws_excp,
  input  logic [EXCP_WIDTH-1:0] ws_excp_num,
  output logic                  btn_n,
  output logic                  heartbeat,
  output logic [PC_WIDTH-1:0]   heartbeat_pc,
  output logic                  running,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic                  stall
);

  localparam int unsigned PhaseMax = (PRE_CYCLES > PULSE_CYCLES) ? PRE_CYCLES : PULSE_CYCLES;
  localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
  localparam int unsigned PressW   = (NUM_RESETS > 0) ? $clog2(NUM_RESETS + 1) : 1;
  localparam int unsigned HbW      = $clog2(HEARTBEAT_CYCLES + 1);
  localparam int unsigned ToW      = $clog2(TIMEOUT_CYCLES + 64'd1);
  localparam int unsigned StallW   = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;

  localparam logic [PhaseW-1:0]     PreLast   = PhaseW'(PRE_CYCLES - 1);
  localparam logic [PhaseW-1:0]     PulseLast = PhaseW'(PULSE_CYCLES - 1);
  localparam logic [PressW-1:0]     PressLast = PressW'(NUM_RESETS);
  localparam logic [HbW-1:0]        HbLast    = HbW'(HEARTBEAT_CYCLES - 1);
  localparam logic [ToW-1:0]        ToLast    = ToW'(TIMEOUT_CYCLES - 64'd1);
  localparam logic [StallW-1:0]     StallLast = (STALL_CYCLES > 0) ? StallW'(STALL_CYCLES - 1) : '0;
  localparam logic [EXCP_WIDTH-1:0] SuccMask  = EXCP_WIDTH'(1) << SUCCESS_BIT;

  typedef enum logic [2:0] {
    StPre,
    StPulse,
    StRun,
    StPass,
    StTimeout,
    StStall
  } state_e;

  localparam state_e StReset = (NUM_RESETS == 0) ? StRun : StPre;

  state_e                state_q, state_d;
  logic [PhaseW-1:0]     phase_q, phase_d;
  logic [PressW-1:0]     press_q, press_d;
  logic [HbW-1:0]        hb_cnt_q, hb_cnt_d;
  logic [ToW-1:0]        to_cnt_q, to_cnt_d;
  logic [StallW-1:0]     stall_cnt_q, stall_cnt_d;
  logic [PC_WIDTH-1:0]   pc_prev_q, pc_prev_d;
  logic                  btn_n_q, btn_n_d;
  logic                  heartbeat_q, heartbeat_d;
  logic [PC_WIDTH-1:0]   heartbeat_pc_q, heartbeat_pc_d;
  logic                  running_q, running_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic                  stall_q, stall_d;

  logic                  hb_wrap;
  logic                  success;
  logic                  pass_hit;
  logic                  to_hit;
  logic                  stall_hit;
  logic [PressW-1:0]     press_inc;

  assign success   = ws_excp & (|(ws_excp_num & SuccMask));
  assign press_inc = press_q + PressW'(1);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    press_d     = press_q;
    hb_cnt_d    = hb_cnt_q;
    to_cnt_d    = to_cnt_q;
    stall_cnt_d = stall_cnt_q;
    hb_wrap     = 1'b0;
    pass_hit    = 1'b0;
    to_hit      = 1'b0;
    stall_hit   = 1'b0;

    case (state_q)
      StPre: begin
        if (phase_q == PreLast) begin
          phase_d = '0;
          state_d = StPulse;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StPulse: begin
        if (phase_q == PulseLast) begin
          phase_d = '0;
          press_d = press_inc;
          state_d = (press_inc == PressLast) ? StRun : StPre;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StRun: begin
        // Heartbeat phase starts once running is visible, so the first strobe lands a full
        // period after the running flag rises.
        if (running_q) begin
          if (hb_cnt_q == HbLast) begin
            hb_cnt_d = '0;
            hb_wrap  = 1'b1;
          end else begin
            hb_cnt_d = hb_cnt_q + HbW'(1);
          end
        end

        to_hit   = (to_cnt_q == ToLast);
        to_cnt_d = to_cnt_q + ToW'(1);

        if (wb_pc != pc_prev_q) begin
          stall_cnt_d = '0;
        end else if (STALL_CYCLES > 0) begin
          if (stall_cnt_q == StallLast) begin
            stall_hit = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + StallW'(1);
          end
        end

        pass_hit = success & (CONT_CHECK | hb_wrap);

        if (pass_hit) begin
          state_d = StPass;
        end else if (to_hit) begin
          state_d = StTimeout;
        end else if (stall_hit) begin
          state_d = StStall;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    pc_prev_d      = wb_pc;
    btn_n_d        = (state_q != StPulse);
    heartbeat_d    = hb_wrap;
    heartbeat_pc_d = hb_wrap ? wb_pc : heartbeat_pc_q;
    running_d      = (state_q == StRun) && (state_d == StRun);
    pass_d         = (state_d == StPass);
    timeout_d      = (state_d == StTimeout);
    stall_d        = (state_d == StStall);
    done_d         = pass_d | timeout_d | stall_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StReset;
      phase_q        <= '0;
      press_q        <= '0;
      hb_cnt_q       <= '0;
      to_cnt_q       <= '0;
      stall_cnt_q    <= '0;
      pc_prev_q      <= '0;
      btn_n_q        <= 1'b1;
      heartbeat_q    <= 1'b0;
      heartbeat_pc_q <= '0;
      running_q      <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
      stall_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      press_q        <= press_d;
      hb_cnt_q       <= hb_cnt_d;
      to_cnt_q       <= to_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
      pc_prev_q      <= pc_prev_d;
      btn_n_q        <= btn_n_d;
      heartbeat_q    <= heartbeat_d;
      heartbeat_pc_q <= heartbeat_pc_d;
      running_q      <= running_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      timeout_q      <= timeout_d;
      stall_q        <= stall_d;
    end
  end

  assign btn_n        = btn_n_q;
  assign heartbeat    = heartbeat_q;
  assign heartbeat_pc = heartbeat_pc_q;
  assign running      = running_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign stall        = stall_q;

endmodule

// File: tb/tb_soc_run_monitor.sv
// Bench for soc_run_monitor: two instances (two presses / CONT_CHECK=0, and no presses /
// CONT_CHECK=1) share stimulus and are compared every cycle against a cycle-count model.
module tb_soc_run_monitor;

  localparam int P = 8;
  localparam int U = 3;
  localparam int H = 16;
  localparam int T = 200;
  localparam int S = 50;
  localparam logic [31:0] PcBase = 32'h1c00_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] wb_pc = '0;
  logic        ws_excp = 1'b0;
  logic [6:0]  ws_excp_num = '0;

  logic        btn_n [2];
  logic        heartbeat [2];
  logic [31:0] heartbeat_pc [2];
  logic        running [2];
  logic        done [2];
  logic        pass [2];
  logic        timeout [2];
  logic        stall [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  soc_run_monitor #(
    .PC_WIDTH(32), .EXCP_WIDTH(7), .SUCCESS_BIT(6), .NUM_RESETS(2), .PRE_CYCLES(P),
    .PULSE_CYCLES(U), .HEARTBEAT_CYCLES(H), .TIMEOUT_CYCLES(64'd200), .STALL_CYCLES(S),
    .CONT_CHECK(1'b0)
  ) u_dut_a (
    .clock(clock), .reset(reset), .wb_pc(wb_pc), .ws_excp(ws_excp),
    .ws_excp_num(ws_excp_num), .btn_n(btn_n[0]), .heartbeat(heartbeat[0]),
    .heartbeat_pc(heartbeat_pc[0]), .running(running[0]), .done(done[0]), .pass(pass[0]),
    .timeout(timeout[0]), .stall(stall[0])
  );

  soc_run_monitor #(
    .PC_WIDTH(32), .EXCP_WIDTH(7), .SUCCESS_BIT(6), .NUM_RESETS(0), .PRE_CYCLES(P),
    .PULSE_CYCLES(U), .HEARTBEAT_CYCLES(H), .TIMEOUT_CYCLES(64'd200), .STALL_CYCLES(S),
    .CONT_CHECK(1'b1)
  ) u_dut_b (
    .clock(clock), .reset(reset), .wb_pc(wb_pc), .ws_excp(ws_excp),
    .ws_excp_num(ws_excp_num), .btn_n(btn_n[1]), .heartbeat(heartbeat[1]),
    .heartbeat_pc(heartbeat_pc[1]), .running(running[1]), .done(done[1]), .pass(pass[1]),
    .timeout(timeout[1]), .stall(stall[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: cyc is the index of the next clock edge since reset release.
  int          cyc = 0;
  logic [31:0] last_pc = '0;
  int          term [2];      // 0 none, 1 pass, 2 timeout, 3 stall
  int          same_run [2];  // consecutive RUN edges with PC unchanged
  logic        e_btn [2];
  logic        e_hb [2];
  logic [31:0] e_hbpc [2];
  logic        e_run [2];

  function automatic int n_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic bit press_at(input int n, input int c);
    for (int k = 0; k < n; k++) begin
      if (c >= k * (P + U) + P + 1 && c <= k * (P + U) + P + U) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step(input logic r, input logic [31:0] pc, input logic ex,
                            input logic [6:0] num);
    for (int i = 0; i < 2; i++) begin
      int re;
      int j;
      bit wrap;
      bit p_hit;
      if (r) begin
        term[i]     = 0;
        same_run[i] = 0;
        e_btn[i]    = 1'b1;
        e_hb[i]     = 1'b0;
        e_hbpc[i]   = '0;
        e_run[i]    = 1'b0;
      end else begin
        re       = n_of(i) * (P + U);
        e_btn[i] = !press_at(n_of(i), cyc + 1);
        e_hb[i]  = 1'b0;
        if (cyc >= re && term[i] == 0) begin
          j           = cyc - re;
          wrap        = (j >= 1) && (j % H == 0);
          same_run[i] = (pc == last_pc) ? same_run[i] + 1 : 0;
          p_hit       = ex && num[6] && ((i == 1) || wrap);
          e_hb[i]     = wrap;
          if (wrap) e_hbpc[i] = pc;
          if (p_hit) term[i] = 1;
          else if (j == T - 1) term[i] = 2;
          else if (same_run[i] == S) term[i] = 3;
        end
        e_run[i] = (cyc >= re) && (term[i] == 0);
      end
    end
    last_pc = r ? 32'h0 : pc;
    cyc     = r ? 0 : cyc + 1;
  endtask

  // Called at a falling edge: drive inputs, advance model, then compare at next falling edge.
  task automatic tick(input logic r, input logic [31:0] pc, input logic ex, input logic [6:0] num);
    string p;
    reset       = r;
    wb_pc       = pc;
    ws_excp     = ex;
    ws_excp_num = num;
    model_step(r, pc, ex, num);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? "a" : "b";
      check_eq({p, "_btn_n"}, btn_n[i], e_btn[i]);
      check_eq({p, "_heartbeat"}, heartbeat[i], e_hb[i]);
      check_eq({p, "_hb_pc"}, heartbeat_pc[i], e_hbpc[i]);
      check_eq({p, "_running"}, running[i], e_run[i]);
      check_eq({p, "_done"}, done[i], term[i] != 0);
      check_eq({p, "_pass"}, pass[i], term[i] == 1);
      check_eq({p, "_timeout"}, timeout[i], term[i] == 2);
      check_eq({p, "_stall"}, stall[i], term[i] == 3);
    end
  endtask

  task automatic do_reset();
    tick(1'b1, 32'h0, 1'b0, 7'h0);
    tick(1'b1, 32'h0, 1'b0, 7'h0);
  endtask

  initial begin
    int rise_a;
    int rise_b;
    int first_low;
    int low_a;
    int low_b;
    int j;
    int len;
    logic [31:0] pc;
    logic [31:0] pc_w;
    logic ex;

    @(negedge clock);

    // Press sequence; exceptions during PRE/PULSE must not affect the two-press instance.
    do_reset();
    check_eq("a_rst_btn", btn_n[0], 1'b1);
    check_eq("a_rst_run", running[0], 1'b0);
    rise_a = -1; low_a = 0; low_b = 0;
    for (int c = 0; c < 60; c++) begin
      ex = (c < 22) && ($urandom_range(0, 2) == 0);
      tick(1'b0, PcBase + 32'(c * 4), ex, 7'($urandom));
      if (c == 0) check_eq("b_run_c1", running[1], 1'b1);
      if (running[0] && rise_a < 0) rise_a = cyc;
      if (!btn_n[0]) low_a++;
      if (!btn_n[1]) low_b++;
    end
    check_eq("a_run_rise", rise_a, 23);
    check_eq("a_btn_low_cnt", low_a, 6);
    check_eq("b_btn_low_cnt", low_b, 0);

    // Success pulse off-boundary (ignored), then held across the second heartbeat.
    do_reset();
    rise_a = -1; pc = PcBase; pc_w = '0;
    for (int c = 0; c < 80; c++) begin
      j  = c - 22;
      pc = pc + 32'(4 * $urandom_range(1, 15));
      ex = (j == 21) || (j >= 30 && j <= 34);
      if (j == 32) pc_w = pc;
      tick(1'b0, pc, ex, {1'b1, 6'($urandom)});
      if (pass[0] && rise_a < 0) rise_a = cyc;
    end
    check_eq("a_pass_rise", rise_a, 55);
    check_eq("a_pass_hb_pc", heartbeat_pc[0], pc_w);

    // Timeout; success exactly on the instance-b timeout edge wins as pass.
    do_reset();
    rise_a = -1; rise_b = -1;
    for (int c = 0; c < 230; c++) begin
      tick(1'b0, PcBase + 32'(c * 4), c == 199, 7'h40);
      if (timeout[0] && rise_a < 0) rise_a = cyc;
      if (pass[1] && rise_b < 0) rise_b = cyc;
    end
    check_eq("a_timeout_rise", rise_a, 222);
    check_eq("a_timeout_nopass", pass[0], 1'b0);
    check_eq("b_pass_rise", rise_b, 200);
    check_eq("b_pass_not_to", timeout[1], 1'b0);

    // Frozen PC.
    do_reset();
    rise_a = -1; rise_b = -1;
    for (int c = 0; c < 120; c++) begin
      tick(1'b0, 32'h1c00_0100, 1'b0, 7'h0);
      if (stall[0] && rise_a < 0) rise_a = cyc;
      if (stall[1] && rise_b < 0) rise_b = cyc;
    end
    check_eq("a_stall_rise", rise_a, 72);
    check_eq("b_stall_rise", rise_b, 51);

    // Reset during the second press replays the whole sequence.
    do_reset();
    for (int c = 0; c < 21; c++) tick(1'b0, PcBase + 32'(c * 4), 1'b0, 7'h0);
    check_eq("a_btn_press2", btn_n[0], 1'b0);
    tick(1'b1, PcBase, 1'b0, 7'h0);
    check_eq("a_btn_after_rst", btn_n[0], 1'b1);
    rise_a = -1; first_low = -1;
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, PcBase + 32'(c * 4), 1'b0, 7'h0);
      if (!btn_n[0] && first_low < 0) first_low = cyc;
      if (running[0] && rise_a < 0) rise_a = cyc;
    end
    check_eq("a_replay_low", first_low, 9);
    check_eq("a_replay_run", rise_a, 23);

    // Random traffic with sparse exceptions, PC dwell and occasional resets.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      len = $urandom_range(100, 250);
      pc  = PcBase + 32'($urandom_range(0, 255) * 4);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 7) == 0) pc = PcBase + 32'($urandom_range(0, 3) * 4);
        ex = ($urandom_range(0, 19) == 0);
        tick($urandom_range(0, 149) == 0, pc, ex, 7'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
